// File: rtl/decode_stage_pkg.sv
// Shared pipeline definitions: opcodes, instruction fields, widths.
// Imported by the decode stage, its interface and its register file.
package pipeline_defs;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int NREGS      = 16;

  localparam int OP_LO  = 12;
  localparam int RD_LO  = 8;
  localparam int RS1_LO = 4;
  localparam int RS2_LO = 0;
  localparam int IMM_LO = 0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_BEQZ = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;

  function automatic logic [3:0] f_op(input logic [15:0] ins);
    return ins[OP_LO +: 4];
  endfunction

  function automatic logic [3:0] f_rd(input logic [15:0] ins);
    return ins[RD_LO +: 4];
  endfunction

  function automatic logic [3:0] f_rs1(input logic [15:0] ins);
    return ins[RS1_LO +: 4];
  endfunction

  function automatic logic [3:0] f_rs2(input logic [15:0] ins);
    return ins[RS2_LO +: 4];
  endfunction

  function automatic logic [7:0] f_imm(input logic [15:0] ins);
    return ins[IMM_LO +: 8];
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Decode-stage bus: fetch handshake, execute handshake,
// writeback port, flush and jump redirect.
interface decode_stage_if
  import pipeline_defs::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_instr;
  logic [ADDR_W-1:0] in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_op;
  logic [3:0]        out_rd;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [7:0]        out_imm;
  logic              out_we;
  logic [ADDR_W-1:0] out_pc;
  logic              out_illegal;
  logic              wb_en;
  logic [3:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    output wb_en, wb_addr, wb_data, flush,
    input  in_ready, out_valid, out_op, out_rd,
    input  out_a, out_b, out_imm, out_we, out_pc,
    input  out_illegal, redirect_valid, redirect_addr
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    input  wb_en, wb_addr, wb_data, flush,
    output in_ready, out_valid, out_op, out_rd,
    output out_a, out_b, out_imm, out_we, out_pc,
    output out_illegal, redirect_valid, redirect_addr
  );
endinterface

// File: rtl/decode_stage_regfile.sv
// 16-entry register file, two combinational read ports, one write.
// r0 is hard zero; same-cycle writes bypass to the read ports.
module regfile_2r1w
  import pipeline_defs::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [3:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        raddr_a_i,
  input  logic [3:0]        raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [NREGS];

  // register storage: cleared on reset, r0 never written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != 4'd0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // read ports with write-through bypass
  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    rdata_b_o = regs_q[raddr_b_i];
    if (we_i && waddr_i == raddr_a_i) rdata_a_o = wdata_i;
    if (we_i && waddr_i == raddr_b_i) rdata_b_o = wdata_i;
    if (raddr_a_i == 4'd0) rdata_a_o = '0;
    if (raddr_b_i == 4'd0) rdata_b_o = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field decode, operand read, local JMP resolution,
// single registered output bundle under valid/ready.
module decode_stage
  import pipeline_defs::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic            clk,
  input logic            rst,
  decode_stage_if.slave  bus
);

  logic [3:0]        op, rd, rs1, rs2;
  logic [7:0]        imm;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic              accept, is_jmp, illegal, we;

  logic              valid_q, valid_d;
  logic [3:0]        op_q, op_d;
  logic [3:0]        rd_q, rd_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [7:0]        imm_q, imm_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ill_q, ill_d;
  logic              redir_q, redir_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;

  assign op  = f_op(bus.in_instr);
  assign rd  = f_rd(bus.in_instr);
  assign rs1 = f_rs1(bus.in_instr);
  assign rs2 = f_rs2(bus.in_instr);
  assign imm = f_imm(bus.in_instr);

  regfile_2r1w #(.DATA_W(DATA_W)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .we_i      (bus.wb_en),
    .waddr_i   (bus.wb_addr),
    .wdata_i   (bus.wb_data),
    .raddr_a_i (rs1),
    .raddr_b_i (rs2),
    .rdata_a_o (rdata_a),
    .rdata_b_o (rdata_b)
  );

  assign bus.in_ready = redir_q || !valid_q || bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready
               && !redir_q && !bus.flush;

  // opcode classification
  always_comb begin
    is_jmp  = 1'b0;
    illegal = 1'b0;
    we      = 1'b0;
    unique case (1'b1)
      op == OP_JMP:                   is_jmp  = 1'b1;
      op > OP_JMP:                    illegal = 1'b1;
      op >= OP_ADD && op <= OP_LDI:   we      = (rd != 4'd0);
      default: ;
    endcase
  end

  // next-state for the output bundle and the redirect pulse
  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    rd_d    = rd_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    we_d    = we_q;
    pc_d    = pc_q;
    ill_d   = ill_q;
    redir_d = accept && is_jmp;
    raddr_d = raddr_q;
    if (accept && is_jmp) raddr_d = ADDR_W'(imm);
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept && !is_jmp) begin
      valid_d = 1'b1;
      op_d    = illegal ? OP_NOP : op;
      rd_d    = rd;
      a_d     = rdata_a;
      b_d     = rdata_b;
      imm_d   = imm;
      we_d    = we;
      pc_d    = bus.in_pc;
      ill_d   = illegal;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      we_q    <= 1'b0;
      pc_q    <= '0;
      ill_q   <= 1'b0;
      redir_q <= 1'b0;
      raddr_q <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      we_q    <= we_d;
      pc_q    <= pc_d;
      ill_q   <= ill_d;
      redir_q <= redir_d;
      raddr_q <= raddr_d;
    end
  end

  assign bus.out_valid      = valid_q;
  assign bus.out_op         = op_q;
  assign bus.out_rd         = rd_q;
  assign bus.out_a          = a_q;
  assign bus.out_b          = b_q;
  assign bus.out_imm        = imm_q;
  assign bus.out_we         = we_q;
  assign bus.out_pc         = pc_q;
  assign bus.out_illegal    = ill_q;
  assign bus.redirect_valid = redir_q;
  assign bus.redirect_addr  = raddr_q;

endmodule
